load_align_unit: RTL and testbench
==================================

# load_align_unit

Parametrised, registered load unit for the RISC-V core's memory stage. It replaces the purely combinational load extractor with a small state machine that issues one or two aligned bus reads, tolerates wait states and error responses, merges boundary-crossing (misaligned) loads, and returns a sign- or zero-extended result with a valid pulse. It sits between the execute/memory stage and the AHB master interface.

## Interface
Parameters:
- XLEN, 32: data and address width; 32 or 64 only. B = XLEN/8 bytes per beat, OFS = log2(B).
- MISALIGN_EN, 1: 1 = split boundary-crossing loads into two beats; 0 = reject them with misaligned_out.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- req_valid_in  input  1  load request valid.
- req_ready_out  output  1  unit can accept a request (high only in IDLE).
- addr_in  input  XLEN  byte address of load.
- load_size_in  input  2  00 byte, 01 half, 10 word, 11 double (XLEN=64); 11 behaves as word when XLEN=32.
- load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
- bus_req_out  output  1  bus read request.
- bus_addr_out  output  XLEN  aligned beat address (low OFS bits zero).
- bus_ready_in  input  1  beat complete; bus_data_in/ahb_resp_in valid.
- bus_data_in  input  XLEN  read data.
- ahb_resp_in  input  1  0 = OKAY, 1 = ERROR; sampled only with bus_ready_in.
- lu_valid_out  output  1  one-cycle pulse: result ready.
- lu_output  output  XLEN  extended load result.
- lu_error_out  output  1  bus error on this load (with lu_valid_out).
- misaligned_out  output  1  load rejected as misaligned (with lu_valid_out).

## Operation
- Capture on req_valid_in && req_ready_out: addr, size, unsigned flag. Size bytes N = 1,2,4,8. off = addr[OFS-1:0]. cross = (off + N > B).
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready_out=1. On accept: if cross && !MISALIGN_EN -> RESP with misaligned flag, no bus access; else -> BEAT0.
- BEAT0: bus_req_out=1, bus_addr_out = addr with low OFS bits cleared. Held stable until bus_ready_in. On bus_ready_in: ahb_resp_in=1 -> RESP with error; else store buf_lo; cross -> BEAT1, else -> RESP.
- BEAT1: bus_req_out=1, bus_addr_out = aligned addr + B (wraps modulo 2^XLEN). On bus_ready_in: error -> RESP with error; else store buf_hi -> RESP.
- RESP: lu_valid_out=1 for exactly one cycle, flags valid; -> IDLE.
- Merge: {buf_hi, buf_lo} (2*XLEN) shifted right by off*8; take low N bytes; bit N*8-1 extended (sign) or zero-filled to XLEN.
- Error or misaligned: lu_output = 0. lu_error_out and misaligned_out mutually exclusive.
- lu_output and flags are registered; lu_output holds its last value between pulses; flags low outside RESP.

## Timing
- Reset: state IDLE; bus_req_out, lu_valid_out, lu_error_out, misaligned_out, lu_output, bus_addr_out all 0; req_ready_out 0 during reset cycle, 1 the cycle after reset deasserts.
- Accept at edge E0 -> bus_req_out high from the cycle after E0. Beat completes at the edge where bus_ready_in=1.
- Aligned, zero wait: lu_valid_out high 2 cycles after acceptance. Crossing, zero wait: 3 cycles. Each wait state adds 1. Misaligned reject: 1 cycle.
- No new request accepted before the RESP cycle ends; earliest next accept is the cycle after RESP (minimum 3-cycle issue interval for aligned loads).
- bus_ready_in while bus_req_out=0 is ignored.
- Reset mid-operation: transaction abandoned, no lu_valid_out pulse; bus_req_out low the cycle after reset is sampled.
- Error on BEAT0 of a crossing load: BEAT1 not issued.

## Test plan
- XLEN=32, LB signed at 0x1001, bus data 0x8899AABB, no waits -> lu_output 0xFFFFFFAA, valid 2 cycles after accept; LBU -> 0x000000AA.
- XLEN=32, LH signed at 0x1003: beat0 addr 0x1000 data 0x11223344, beat1 addr 0x1004 data 0x55667788 -> lu_output 0xFFFF8811 after 3 cycles; LHU -> 0x00008811.
- XLEN=32, LW at 0x2000, bus_ready_in low 3 cycles -> bus_addr_out stable 0x2000 throughout, lu_output = bus data, valid 5 cycles after accept.
- XLEN=32, LW at 0x3002 with ahb_resp_in=1 on beat0 -> no beat1, lu_error_out=1, lu_output 0; MISALIGN_EN=0 same request -> misaligned_out=1 after 1 cycle, bus_req_out never asserted.
- XLEN=64, LD at 0x...0FFC crossing: beats at 0x...0FF8 and 0x...1000 -> correct 8-byte merge; LW signed at 0x4004, data upper word 0x80000000 -> 0xFFFFFFFF80000000.
- Reset asserted during BEAT1 wait -> no valid pulse, bus_req_out low next cycle, req_ready_out 1 after reset release.

Source files
------------

// File: rtl/load_align_unit.sv
// Registered load unit: issues one or two aligned bus beats per load, merges
// boundary-crossing data and returns a sign- or zero-extended result.
module load_align_unit #(
    parameter int XLEN        = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic [XLEN-1:0] addr_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    output logic            bus_req_out,
    output logic [XLEN-1:0] bus_addr_out,
    input  logic            bus_ready_in,
    input  logic [XLEN-1:0] bus_data_in,
    input  logic            ahb_resp_in,
    output logic            lu_valid_out,
    output logic [XLEN-1:0] lu_output,
    output logic            lu_error_out,
    output logic            misaligned_out
);

    localparam int B   = XLEN / 8;
    localparam int OFS = $clog2(B);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t          state_reg, state_next;
    logic [OFS-1:0]  off_reg;
    logic [1:0]      size_reg;
    logic            uns_reg;
    logic            cross_reg;
    logic [XLEN-1:0] buf_lo_reg;
    logic [XLEN-1:0] bus_addr_reg;
    logic [XLEN-1:0] lu_output_reg;
    logic            lu_valid_reg;
    logic            lu_error_reg;
    logic            misaligned_reg;

    logic [1:0]      req_size;
    logic [OFS+1:0]  req_end;
    logic            req_cross;
    logic            accept;
    logic            reject;
    logic            beat_done;

    // Double-width loads do not exist on a 32-bit bus; treat them as words.
    assign req_size  = (XLEN == 32 && load_size_in == 2'b11) ? 2'b10 : load_size_in;
    assign req_end   = {2'b00, addr_in[OFS-1:0]} + ((OFS+2)'(1) << req_size);
    assign req_cross = (req_end > (OFS+2)'(B));

    assign req_ready_out = (state_reg == IDLE) && !reset_in;
    assign accept        = req_valid_in && req_ready_out;
    assign reject        = req_cross && (MISALIGN_EN == 0);
    assign bus_req_out   = (state_reg == BEAT0) || (state_reg == BEAT1);
    assign beat_done     = bus_req_out && bus_ready_in;

    assign bus_addr_out   = bus_addr_reg;
    assign lu_output      = lu_output_reg;
    assign lu_valid_out   = lu_valid_reg;
    assign lu_error_out   = lu_error_reg;
    assign misaligned_out = misaligned_reg;

    // Merge and extend from the live beat so the result registers on the
    // same edge that completes the final beat.
    logic [XLEN-1:0] merge_lo;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign_bit;
    logic [XLEN-1:0] ext;

    assign merge_lo = (state_reg == BEAT1) ? buf_lo_reg : bus_data_in;
    assign shifted  = XLEN'({bus_data_in, merge_lo} >> {off_reg, 3'b000});

    always_comb begin
        mask     = '0;
        sign_bit = 1'b0;
        case (size_reg)
            2'd0: begin
                mask[7:0] = '1;
                sign_bit  = shifted[7];
            end
            2'd1: begin
                mask[15:0] = '1;
                sign_bit   = shifted[15];
            end
            2'd2: begin
                mask[31:0] = '1;
                sign_bit   = shifted[31];
            end
            default: begin
                mask     = '1;
                sign_bit = shifted[XLEN-1];
            end
        endcase
        ext = (shifted & mask) | ((!uns_reg && sign_bit) ? ~mask : '0);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = reject ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                if (beat_done) begin
                    state_next = (ahb_resp_in || !cross_reg) ? RESP : BEAT1;
                end
            end
            BEAT1: begin
                if (beat_done) begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg      <= IDLE;
            off_reg        <= '0;
            size_reg       <= '0;
            uns_reg        <= 1'b0;
            cross_reg      <= 1'b0;
            buf_lo_reg     <= '0;
            bus_addr_reg   <= '0;
            lu_output_reg  <= '0;
            lu_valid_reg   <= 1'b0;
            lu_error_reg   <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lu_valid_reg   <= 1'b0;
            lu_error_reg   <= 1'b0;
            misaligned_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        off_reg      <= addr_in[OFS-1:0];
                        size_reg     <= req_size;
                        uns_reg      <= load_unsigned_in;
                        cross_reg    <= req_cross;
                        bus_addr_reg <= {addr_in[XLEN-1:OFS], {OFS{1'b0}}};
                        if (reject) begin
                            lu_valid_reg   <= 1'b1;
                            misaligned_reg <= 1'b1;
                            lu_output_reg  <= '0;
                        end
                    end
                end
                BEAT0: begin
                    if (beat_done) begin
                        if (ahb_resp_in) begin
                            lu_valid_reg  <= 1'b1;
                            lu_error_reg  <= 1'b1;
                            lu_output_reg <= '0;
                        end else if (cross_reg) begin
                            buf_lo_reg   <= bus_data_in;
                            bus_addr_reg <= bus_addr_reg + XLEN'(B);
                        end else begin
                            buf_lo_reg    <= bus_data_in;
                            lu_valid_reg  <= 1'b1;
                            lu_output_reg <= ext;
                        end
                    end
                end
                BEAT1: begin
                    if (beat_done) begin
                        lu_valid_reg  <= 1'b1;
                        lu_error_reg  <= ahb_resp_in;
                        lu_output_reg <= ahb_resp_in ? '0 : ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three instances (32-bit, 32-bit reject-misaligned,
// 64-bit) driven by directed loads, results checked by a scoreboard monitor.
module tb_load_align_unit;

    logic        clk;
    logic        srst;
    logic [2:0]  req_valid, req_ready, uns, bus_req, bus_ready, resp;
    logic [2:0]  lu_valid, lu_err, lu_mis;
    logic [1:0]  size [3];
    logic [63:0] addr [3];
    logic [63:0] bus_data [3];
    logic [63:0] bus_addr [3];
    logic [63:0] lu_out [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int XL = (gi == 2) ? 64 : 32;
        localparam int ME = (gi == 1) ? 0 : 1;
        logic [XL-1:0] ba_w, lo_w;
        load_align_unit #(.XLEN(XL), .MISALIGN_EN(ME)) u_dut (
            .clk_in          (clk),
            .reset_in        (srst),
            .req_valid_in    (req_valid[gi]),
            .req_ready_out   (req_ready[gi]),
            .addr_in         (addr[gi][XL-1:0]),
            .load_size_in    (size[gi]),
            .load_unsigned_in(uns[gi]),
            .bus_req_out     (bus_req[gi]),
            .bus_addr_out    (ba_w),
            .bus_ready_in    (bus_ready[gi]),
            .bus_data_in     (bus_data[gi][XL-1:0]),
            .ahb_resp_in     (resp[gi]),
            .lu_valid_out    (lu_valid[gi]),
            .lu_output       (lo_w),
            .lu_error_out    (lu_err[gi]),
            .misaligned_out  (lu_mis[gi])
        );
        assign bus_addr[gi] = 64'(ba_w);
        assign lu_out[gi]   = 64'(lo_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          dut;
        logic [63:0] out;
        logic        err;
        logic        mis;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: pops one expectation per result pulse.
    always @(negedge clk) begin
        if (cyc > 1 && !srst) begin
            for (int k = 0; k < 3; k++) begin
                if (lu_valid[k] === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid dut%0d: got pulse want none", k);
                    end else begin
                        e = sb.pop_front();
                        check("dut_index", 64'(k), 64'(e.dut));
                        check("lu_output", lu_out[k], e.out);
                        check("lu_error", 64'(lu_err[k]), 64'(e.err));
                        check("misaligned", 64'(lu_mis[k]), 64'(e.mis));
                        check("latency_cycle", 64'(cyc), 64'(e.cyc));
                        $display("txn dut%0d out=%h err=%b mis=%b cyc=%0d",
                                 k, lu_out[k], lu_err[k], lu_mis[k], cyc);
                    end
                end else begin
                    check("flags_idle", {62'd0, lu_err[k], lu_mis[k]}, 64'd0);
                end
            end
        end
    end

    task automatic do_load(input int k, input logic [63:0] a, input logic [1:0] sz,
                           input logic u, input int nb,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input int w0, input int w1, input logic e0, input logic e1,
                           input logic [63:0] want, input logic want_e, input logic want_m,
                           input int lat);
        logic [63:0] amask, ba, bd;
        logic        be;
        int          bsz, w;
        amask = (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        bsz   = (k == 2) ? 8 : 4;
        ba    = a & ~64'(bsz - 1) & amask;
        check("req_ready", 64'(req_ready[k]), 64'd1);
        req_valid[k] = 1'b1;
        addr[k]      = a;
        size[k]      = sz;
        uns[k]       = u;
        sb.push_back('{k, want, want_e, want_m, cyc + lat});
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            w  = (b == 0) ? w0 : w1;
            bd = (b == 0) ? d0 : d1;
            be = (b == 0) ? e0 : e1;
            for (int i = 0; i < w; i++) begin
                bus_data[k] = ~bd;
                check("bus_req_wait", 64'(bus_req[k]), 64'd1);
                check("bus_addr_wait", bus_addr[k], ba);
                @(posedge clk); #1;
            end
            bus_ready[k] = 1'b1;
            bus_data[k]  = bd;
            resp[k]      = be;
            check("bus_req_beat", 64'(bus_req[k]), 64'd1);
            check("bus_addr_beat", bus_addr[k], ba);
            @(posedge clk); #1;
            bus_ready[k] = 1'b0;
            resp[k]      = 1'b0;
            ba = (ba + 64'(bsz)) & amask;
        end
        check("bus_req_resp", 64'(bus_req[k]), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid();
        check("req_ready", 64'(req_ready[0]), 64'd1);
        req_valid[0] = 1'b1;
        addr[0]      = 64'h1003;
        size[0]      = 2'd1;
        uns[0]       = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        bus_ready[0] = 1'b1;
        bus_data[0]  = 64'h1122_3344;
        @(posedge clk); #1;
        bus_ready[0] = 1'b0;
        check("rst_beat1_req", 64'(bus_req[0]), 64'd1);
        check("rst_beat1_addr", bus_addr[0], 64'h1004);
        @(posedge clk); #1;
        srst = 1'b1;
        #1;
        check("rst_ready_low", 64'(req_ready[0]), 64'd0);
        @(posedge clk); #1;
        srst = 1'b0;
        #1;
        check("rst_bus_req_low", 64'(bus_req[0]), 64'd0);
        check("rst_ready_after", 64'(req_ready[0]), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        srst      = 1'b1;
        req_valid = '0;
        uns       = '0;
        bus_ready = '0;
        resp      = '0;
        for (int k = 0; k < 3; k++) begin
            size[k]     = 2'd0;
            addr[k]     = 64'd0;
            bus_data[k] = 64'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", 64'(req_ready[k]), 64'd0);
            check("reset_bus_req", 64'(bus_req[k]), 64'd0);
            check("reset_valid", {61'd0, lu_valid[k], lu_err[k], lu_mis[k]}, 64'd0);
            check("reset_output", lu_out[k], 64'd0);
            check("reset_bus_addr", bus_addr[k], 64'd0);
        end
        srst = 1'b0;
        #1;
        check("ready_after_reset", {61'd0, req_ready}, 64'd7);
        @(posedge clk); #1;

        // 32-bit instance
        do_load(0, 64'h1001, 2'd0, 1'b0, 1, 64'h8899AABB, 64'h0, 0, 0, 1'b0, 1'b0, 64'hFFFFFFAA, 1'b0, 1'b0, 2);
        do_load(0, 64'h1001, 2'd0, 1'b1, 1, 64'h8899AABB, 64'h0, 0, 0, 1'b0, 1'b0, 64'h000000AA, 1'b0, 1'b0, 2);
        do_load(0, 64'h1003, 2'd1, 1'b0, 2, 64'h11223344, 64'h55667788, 0, 0, 1'b0, 1'b0, 64'hFFFF8811, 1'b0, 1'b0, 3);
        do_load(0, 64'h1003, 2'd1, 1'b1, 2, 64'h11223344, 64'h55667788, 0, 0, 1'b0, 1'b0, 64'h00008811, 1'b0, 1'b0, 3);
        do_load(0, 64'h2000, 2'd2, 1'b0, 1, 64'hDEADBEEF, 64'h0, 3, 0, 1'b0, 1'b0, 64'hDEADBEEF, 1'b0, 1'b0, 5);
        do_load(0, 64'h3002, 2'd2, 1'b0, 1, 64'hCAFEF00D, 64'h0, 0, 0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 2);
        do_load(0, 64'h1002, 2'd1, 1'b0, 1, 64'h8899AABB, 64'h0, 0, 0, 1'b0, 1'b0, 64'hFFFF8899, 1'b0, 1'b0, 2);
        do_load(0, 64'hFFFFFFFE, 2'd2, 1'b0, 2, 64'hAABBCCDD, 64'h11223344, 1, 2, 1'b0, 1'b0, 64'h3344AABB, 1'b0, 1'b0, 6);
        do_load(0, 64'h1003, 2'd2, 1'b0, 2, 64'h01020304, 64'h05060708, 0, 0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 3);
        do_load(0, 64'h2000, 2'd3, 1'b0, 1, 64'h80000001, 64'h0, 0, 0, 1'b0, 1'b0, 64'h80000001, 1'b0, 1'b0, 2);
        // 32-bit instance that rejects boundary-crossing loads
        do_load(1, 64'h3002, 2'd2, 1'b0, 0, 64'h0, 64'h0, 0, 0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1);
        do_load(1, 64'h3000, 2'd2, 1'b1, 1, 64'h12345678, 64'h0, 0, 0, 1'b0, 1'b0, 64'h12345678, 1'b0, 1'b0, 2);
        do_load(1, 64'h1003, 2'd0, 1'b0, 1, 64'h7F000000, 64'h0, 0, 0, 1'b0, 1'b0, 64'h0000007F, 1'b0, 1'b0, 2);
        // 64-bit instance
        do_load(2, 64'h12345678_00000FFC, 2'd3, 1'b0, 2, 64'h07060504_03020100, 64'h0F0E0D0C_0B0A0908,
                0, 0, 1'b0, 1'b0, 64'h0B0A0908_07060504, 1'b0, 1'b0, 3);
        do_load(2, 64'h4004, 2'd2, 1'b0, 1, 64'h80000000_12345678, 64'h0, 0, 0, 1'b0, 1'b0, 64'hFFFFFFFF_80000000, 1'b0, 1'b0, 2);
        do_load(2, 64'h4004, 2'd2, 1'b1, 1, 64'h80000000_12345678, 64'h0, 0, 0, 1'b0, 1'b0, 64'h00000000_80000000, 1'b0, 1'b0, 2);
        do_load(2, 64'h4007, 2'd0, 1'b0, 1, 64'h80FFFFFF_FFFFFFFF, 64'h0, 0, 0, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFF80, 1'b0, 1'b0, 2);
        do_load(2, 64'h4006, 2'd1, 1'b0, 1, 64'h7FEE0000_00000000, 64'h0, 1, 0, 1'b0, 1'b0, 64'h00000000_00007FEE, 1'b0, 1'b0, 3);

        reset_mid();
        do_load(0, 64'h1001, 2'd0, 1'b1, 1, 64'h8899AABB, 64'h0, 0, 0, 1'b0, 1'b0, 64'h000000AA, 1'b0, 1'b0, 2);

        repeat (5) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid dut%0d: got no pulse want out=%h", e.dut, e.out);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
